// File: rtl/cdb_arbiter.sv
// cdb_arbiter: picks up to four completing functional units per cycle with
// rotating priority and drives them onto the four registered CDB lanes.
//
// Ports:
//   clock, reset      system clock; asynchronous active-high reset
//   squash            synchronous flush: no grants, lanes cleared, pointer to 0
//   fu_req            per-FU completed-result request
//   fu_tag/fu_result  flat per-FU destination tag / result value
//   fu_grant          combinational per-FU grant (same cycle as fu_req)
//   cdb_pr_ready      registered lane valid bits
//   cdb_pr_tag_k      registered lane tags, k = 0..3
//   cdb_value_k       registered lane values, k = 0..3

// One registered CDB lane. Loads every cycle; an idle lane loads zeros so
// stale tags never linger on the bus.
module cdb_lane_reg #(
  parameter int TAG_W  = 7,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              squash,
  input  logic              load_vld,
  input  logic [TAG_W-1:0]  load_tag,
  input  logic [DATA_W-1:0] load_val,
  output logic              ready,
  output logic [TAG_W-1:0]  tag,
  output logic [DATA_W-1:0] value
);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready <= 1'b0;
      tag   <= '0;
      value <= '0;
    end else if (squash || !load_vld) begin
      ready <= 1'b0;
      tag   <= '0;
      value <= '0;
    end else begin
      ready <= 1'b1;
      tag   <= load_tag;
      value <= load_val;
    end
  end
endmodule

module cdb_arbiter #(
  parameter int NUM_FU = 6,
  parameter int TAG_W  = 7,
  parameter int DATA_W = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     squash,
  input  logic [NUM_FU-1:0]        fu_req,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU*DATA_W-1:0] fu_result,
  output logic [NUM_FU-1:0]        fu_grant,
  output logic [3:0]               cdb_pr_ready,
  output logic [TAG_W-1:0]         cdb_pr_tag_0,
  output logic [TAG_W-1:0]         cdb_pr_tag_1,
  output logic [TAG_W-1:0]         cdb_pr_tag_2,
  output logic [TAG_W-1:0]         cdb_pr_tag_3,
  output logic [DATA_W-1:0]        cdb_value_0,
  output logic [DATA_W-1:0]        cdb_value_1,
  output logic [DATA_W-1:0]        cdb_value_2,
  output logic [DATA_W-1:0]        cdb_value_3
);
  localparam int NUM_LANES = 4;
  localparam int PTR_W     = $clog2(NUM_FU);
  localparam logic [PTR_W:0]   NUM_FU_W = (PTR_W+1)'(NUM_FU);
  localparam logic [PTR_W-1:0] LAST_FU  = PTR_W'(NUM_FU-1);

  logic [PTR_W-1:0]                       rr_ptr, rr_nxt, last_idx;
  logic [NUM_FU-1:0]                      grant;
  logic [NUM_LANES-1:0]                   lane_vld;
  logic [NUM_LANES-1:0][PTR_W-1:0]        lane_src;
  logic [NUM_LANES-1:0][TAG_W-1:0]        lane_tag, q_tag;
  logic [NUM_LANES-1:0][DATA_W-1:0]       lane_val, q_val;
  logic [NUM_LANES-1:0]                   q_rdy;
  logic [PTR_W:0]                         idx_w;
  logic [PTR_W-1:0]                       idx;
  logic [2:0]                             cnt;

  // Scan FUs starting at rr_ptr; the n-th requester found takes lane n.
  // idx_w carries one extra bit so rr_ptr+j can be wrapped without overflow.
  always_comb begin
    grant    = '0;
    lane_vld = '0;
    lane_src = '0;
    cnt      = '0;
    last_idx = rr_ptr;
    idx_w    = '0;
    idx      = '0;
    if (!squash && !reset) begin
      for (int j = 0; j < NUM_FU; j++) begin
        idx_w = {1'b0, rr_ptr} + (PTR_W+1)'(j);
        if (idx_w >= NUM_FU_W) idx_w = idx_w - NUM_FU_W;
        idx = idx_w[PTR_W-1:0];
        if (fu_req[idx] && cnt < 3'd4) begin
          grant[idx]            = 1'b1;
          lane_vld[cnt[1:0]]    = 1'b1;
          lane_src[cnt[1:0]]    = idx;
          cnt                   = cnt + 3'd1;
          last_idx              = idx;
        end
      end
    end
  end

  assign rr_nxt   = (last_idx == LAST_FU) ? '0 : last_idx + PTR_W'(1);
  assign fu_grant = grant;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        rr_ptr <= '0;
    else if (squash)  rr_ptr <= '0;
    else if (|grant)  rr_ptr <= rr_nxt;
  end

  // Idle lanes mux zeros so a non-requesting FU's tag/result is never used.
  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
      assign lane_tag[k] = lane_vld[k] ? fu_tag[lane_src[k]*TAG_W +: TAG_W]      : '0;
      assign lane_val[k] = lane_vld[k] ? fu_result[lane_src[k]*DATA_W +: DATA_W] : '0;

      cdb_lane_reg #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_lane (
        .clock    (clock),
        .reset    (reset),
        .squash   (squash),
        .load_vld (lane_vld[k]),
        .load_tag (lane_tag[k]),
        .load_val (lane_val[k]),
        .ready    (q_rdy[k]),
        .tag      (q_tag[k]),
        .value    (q_val[k])
      );
    end
  endgenerate

  assign cdb_pr_ready = q_rdy;
  assign cdb_pr_tag_0 = q_tag[0];
  assign cdb_pr_tag_1 = q_tag[1];
  assign cdb_pr_tag_2 = q_tag[2];
  assign cdb_pr_tag_3 = q_tag[3];
  assign cdb_value_0  = q_val[0];
  assign cdb_value_1  = q_val[1];
  assign cdb_value_2  = q_val[2];
  assign cdb_value_3  = q_val[3];
endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int NF = 6;
  localparam int TW = 7;
  localparam int DW = 64;

  logic                clock = 1'b0;
  logic                reset, squash;
  logic [NF-1:0]       fu_req;
  logic [NF-1:0][TW-1:0] tagv;
  logic [NF-1:0][DW-1:0] valv;
  logic [NF*TW-1:0]    fu_tag;
  logic [NF*DW-1:0]    fu_result;
  logic [NF-1:0]       fu_grant;
  logic [3:0]          cdb_pr_ready;
  logic [TW-1:0]       cdb_pr_tag_0, cdb_pr_tag_1, cdb_pr_tag_2, cdb_pr_tag_3;
  logic [DW-1:0]       cdb_value_0, cdb_value_1, cdb_value_2, cdb_value_3;

  assign fu_tag    = tagv;
  assign fu_result = valv;

  cdb_arbiter #(.NUM_FU(NF), .TAG_W(TW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_req(fu_req), .fu_tag(fu_tag), .fu_result(fu_result),
    .fu_grant(fu_grant), .cdb_pr_ready(cdb_pr_ready),
    .cdb_pr_tag_0(cdb_pr_tag_0), .cdb_pr_tag_1(cdb_pr_tag_1),
    .cdb_pr_tag_2(cdb_pr_tag_2), .cdb_pr_tag_3(cdb_pr_tag_3),
    .cdb_value_0(cdb_value_0), .cdb_value_1(cdb_value_1),
    .cdb_value_2(cdb_value_2), .cdb_value_3(cdb_value_3)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]          rdy;
    logic [3:0][TW-1:0]  tag;
    logic [3:0][DW-1:0]  val;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected lane contents from FU indices (-1 = idle lane).
  function automatic exp_t mk(input int l0, input int l1, input int l2, input int l3);
    exp_t e;
    int   ls[4];
    ls = '{l0, l1, l2, l3};
    e.rdy = '0; e.tag = '0; e.val = '0;
    for (int k = 0; k < 4; k++)
      if (ls[k] >= 0) begin
        e.rdy[k] = 1'b1;
        e.tag[k] = tagv[ls[k]];
        e.val[k] = valv[ls[k]];
      end
    return e;
  endfunction

  // Monitor: compares the registered lanes against the scoreboard each cycle.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("lane_ready", cdb_pr_ready, e.rdy);
      chk("lane_tags",  {cdb_pr_tag_3, cdb_pr_tag_2, cdb_pr_tag_1, cdb_pr_tag_0}, e.tag);
      chk("lane_vals",  {cdb_value_3, cdb_value_2, cdb_value_1, cdb_value_0}, e.val);
    end
  end

  // Drive one cycle, check the same-cycle grant, queue the next-cycle lanes.
  task automatic step(input logic [NF-1:0] req, input logic sq, input logic [NF-1:0] eg,
                      input int l0, input int l1, input int l2, input int l3);
    @(negedge clock);
    fu_req = req;
    squash = sq;
    #1;
    chk("grant", fu_grant, eg);
    q.push_back(mk(l0, l1, l2, l3));
    @(posedge clock);
    #2;
  endtask

  initial begin
    logic [NF-1:0] pend, eg;
    int ptr_m, n, lastg, worst;
    int ls[4];
    int wait_c[NF];

    reset = 1'b1; squash = 1'b0; fu_req = '1;
    tagv[0] = 7'd32; tagv[1] = 7'd0;   tagv[2] = 7'd33;
    tagv[3] = 7'd17; tagv[4] = 7'd127; tagv[5] = 7'd40;
    for (int i = 0; i < NF; i++) valv[i] = {32'hFEED0000 + 32'(i), 32'h12345670 + 32'(i)};

    // Reset state
    #12;
    chk("rst_ready", cdb_pr_ready, 4'b0000);
    chk("rst_grant", fu_grant, 6'b000000);
    @(negedge clock);
    reset = 1'b0; fu_req = '0;

    // Sparse request
    step(6'b100101, 1'b0, 6'b100101, 0, 2, 5, -1);
    chk("rr_sparse", dut.rr_ptr, 3'd0);
    // Oversubscription
    step(6'b111111, 1'b0, 6'b001111, 0, 1, 2, 3);
    chk("rr_over1", dut.rr_ptr, 3'd4);
    step(6'b111111, 1'b0, 6'b110011, 4, 5, 0, 1);
    chk("rr_over2", dut.rr_ptr, 3'd2);
    // Move pointer to 3, then exactly four requesters with wrap
    step(6'b000100, 1'b0, 6'b000100, 2, -1, -1, -1);
    chk("rr_single", dut.rr_ptr, 3'd3);
    step(6'b011110, 1'b0, 6'b011110, 3, 4, 1, 2);
    chk("rr_four", dut.rr_ptr, 3'd3);
    // Squash then resume
    step(6'b111111, 1'b1, 6'b000000, -1, -1, -1, -1);
    chk("rr_squash", dut.rr_ptr, 3'd0);
    step(6'b111111, 1'b0, 6'b001111, 0, 1, 2, 3);
    chk("rr_resume", dut.rr_ptr, 3'd4);

    // Asynchronous reset mid-stream with lanes valid
    #1;
    reset = 1'b1;
    #1;
    chk("arst_ready", cdb_pr_ready, 4'b0000);
    chk("arst_tags",  {cdb_pr_tag_3, cdb_pr_tag_2, cdb_pr_tag_1, cdb_pr_tag_0}, 0);
    chk("arst_vals",  {cdb_value_3, cdb_value_2, cdb_value_1, cdb_value_0}, 0);
    chk("arst_grant", fu_grant, 6'b000000);
    chk("arst_rr",    dut.rr_ptr, 3'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0; fu_req = '0;
    step(6'b000000, 1'b0, 6'b000000, -1, -1, -1, -1);
    chk("idle_rr", dut.rr_ptr, 3'd0);

    // Random requests under the hold protocol against a reference model
    pend = '0; ptr_m = 0;
    for (int i = 0; i < NF; i++) wait_c[i] = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clock);
      for (int i = 0; i < NF; i++)
        if (!pend[i] && $urandom_range(0, 99) < 60) begin
          pend[i] = 1'b1;
          tagv[i] = 7'($urandom);
          valv[i] = {$urandom, $urandom};
        end
      fu_req = pend; squash = 1'b0;
      eg = '0; n = 0; lastg = -1; ls = '{-1, -1, -1, -1};
      for (int k = 0; k < NF; k++) begin
        int i;
        i = (ptr_m + k) % NF;
        if (pend[i] && n < 4) begin
          eg[i] = 1'b1; ls[n] = i; n++; lastg = i;
        end
      end
      if (n > 0) ptr_m = (lastg + 1) % NF;
      #1;
      chk("rand_grant", fu_grant, eg);
      q.push_back(mk(ls[0], ls[1], ls[2], ls[3]));
      worst = 0;
      for (int i = 0; i < NF; i++)
        if (pend[i]) begin
          if (fu_grant[i]) begin
            pend[i] = 1'b0; wait_c[i] = 0;
          end else begin
            wait_c[i]++;
          end
          if (wait_c[i] > worst) worst = wait_c[i];
        end
      if (worst > 1) begin
        tests++; fails++;
        $display("FAIL starvation: an FU waited %0d ungranted cycles, limit 1", worst);
      end
      @(posedge clock);
    end

    @(negedge clock);
    fu_req = '0;
    @(posedge clock);
    @(posedge clock);
    #3;
    chk("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
